// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM driving the
//            datapath over one handshaked instruction/data memory port.
//            Define MCTRL_BYTE_OPS_EN to enable the LB/SB byte operations.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                word_en,
    output logic                ld_en,
    output logic                ir_write,
    output logic                pc_inc,
    output logic                pc_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                memtoreg,
    output logic                alusrc_a,
    output logic                branch,
    output logic                jump,
    output logic [1:0]          alusrc_b,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired,
    output logic [2:0]          state
);

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALTED = 3'd5;

    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_LB   = 4'h3;
    localparam logic [3:0] c_OP_SB   = 4'h4;
    localparam logic [3:0] c_OP_BNE  = 4'h7;
    localparam logic [3:0] c_OP_HALT = 4'h9;

    localparam logic [ALUOP_W-1:0] c_ALU_MEM = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] c_ALU_ADD = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] c_ALU_SUB = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] c_ALU_J   = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] c_ALU_BEQ = ALUOP_W'(3'b110);
    localparam logic [ALUOP_W-1:0] c_ALU_BNE = ALUOP_W'(3'b111);

    function automatic logic f_legal(input logic [3:0] code);
        logic v_ok;
        v_ok = 1'b0;
        case (code)
            4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: v_ok = 1'b1;
`ifdef MCTRL_BYTE_OPS_EN
            4'h3, 4'h4: v_ok = 1'b1;
`endif
            default: v_ok = 1'b0;
        endcase
        return v_ok;
    endfunction

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [OPCODE_W-1:0] r_op_q;
    logic [CNT_W-1:0]    r_retired;
    logic                r_illegal;
    logic                r_halted;
    logic                w_retire;
    logic                w_set_ill;
    logic                w_set_halt;

    logic       w_in_legal;
    logic [3:0] w_in_code;
    logic [3:0] w_q_code;
    logic       w_is_r;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_br;
    logic       w_is_j;

    assign w_in_code  = opcode[3:0];
    // Any set bit above the 4-bit opcode field makes the instruction illegal
    assign w_in_legal = ((opcode >> 4) == '0) && f_legal(w_in_code);

    // Only legal opcodes ever reach EXEC/MEM/WB, so the low nibble is enough
    assign w_q_code   = r_op_q[3:0];
    assign w_is_r     = (w_q_code == 4'h0) || (w_q_code == 4'h1);
    assign w_is_load  = (w_q_code == 4'h2) || (w_q_code == 4'h3);
    assign w_is_store = (w_q_code == 4'h4) || (w_q_code == 4'h5);
    assign w_is_br    = (w_q_code == 4'h6) || (w_q_code == 4'h7);
    assign w_is_j     = (w_q_code == 4'h8);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        w_set_ill  = 1'b0;
        w_set_halt = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                if (mem_ready) w_next = c_ST_DECODE;
            end
            c_ST_DECODE: begin
                if (!w_in_legal) begin
                    w_set_ill = 1'b1;
                    w_next    = c_ST_FETCH;
                end else if (w_in_code == c_OP_HALT) begin
                    w_retire   = 1'b1;
                    w_set_halt = 1'b1;
                    w_next     = c_ST_HALTED;
                end else begin
                    w_next = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                if (w_is_r) begin
                    w_next = c_ST_WB;
                end else if (w_is_load || w_is_store) begin
                    w_next = c_ST_MEM;
                end else begin
                    w_retire = 1'b1;
                    w_next   = c_ST_FETCH;
                end
            end
            c_ST_MEM: begin
                if (mem_ready) begin
                    if (w_is_load) begin
                        w_next = c_ST_WB;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = c_ST_FETCH;
                    end
                end
            end
            c_ST_WB: begin
                w_retire = 1'b1;
                w_next   = c_ST_FETCH;
            end
            c_ST_HALTED: w_next = c_ST_HALTED;
            default:     w_next = c_ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_q    <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            if (r_state == c_ST_DECODE) r_op_q <= opcode;
            if (w_retire)   r_retired <= r_retired + 1'b1;
            if (w_set_ill)  r_illegal <= 1'b1;
            if (w_set_halt) r_halted  <= 1'b1;
        end
    end

    // Reset forces every output to its idle value, even before the state register settles
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        word_en   = 1'b1;
        ld_en     = 1'b1;
        ir_write  = 1'b0;
        pc_inc    = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        reg_dst   = 1'b0;
        memtoreg  = 1'b0;
        alusrc_a  = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        alusrc_b  = 2'b00;
        aluop     = '0;
        if (!reset) begin
            case (r_state)
                c_ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_inc   = 1'b1;
                    end
                end
                c_ST_EXEC: begin
                    if (w_is_r) begin
                        aluop = (w_q_code == c_OP_SUB) ? c_ALU_SUB : c_ALU_ADD;
                    end else if (w_is_load || w_is_store) begin
                        alusrc_b = 2'b11;
                        aluop    = c_ALU_MEM;
                    end else if (w_is_br) begin
                        branch = 1'b1;
                        aluop  = (w_q_code == c_OP_BNE) ? c_ALU_BNE : c_ALU_BEQ;
                    end else if (w_is_j) begin
                        alusrc_a = 1'b1;
                        alusrc_b = 2'b01;
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        aluop    = c_ALU_J;
                    end
                end
                c_ST_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = w_is_store;
`ifdef MCTRL_BYTE_OPS_EN
                    word_en = (w_q_code != c_OP_SB);
                    ld_en   = (w_q_code != c_OP_LB);
`endif
                end
                c_ST_WB: begin
                    reg_write = 1'b1;
                    if (w_is_r) begin
                        reg_dst = 1'b1;
                    end else begin
                        memtoreg = 1'b1;
`ifdef MCTRL_BYTE_OPS_EN
                        ld_en    = (w_q_code != c_OP_LB);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign halted  = reset ? 1'b0 : r_halted;
    assign illegal = reset ? 1'b0 : r_illegal;
    assign retired = reset ? '0   : r_retired;
    assign state   = reset ? c_ST_FETCH : r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Scoreboard bench for multicycle_ctrl; per-cycle expectations are
//            queued per instruction and compared as the DUT steps through them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

`ifdef MCTRL_BYTE_OPS_EN
    localparam bit c_BYTE_EN = 1'b1;
`else
    localparam bit c_BYTE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode;
    logic        mem_ready;
    logic        mem_req, mem_we, word_en, ld_en, ir_write, pc_inc, pc_write;
    logic        reg_write, reg_dst, memtoreg, alusrc_a, branch, jump;
    logic [1:0]  alusrc_b;
    logic [2:0]  aluop;
    logic        halted, illegal;
    logic [15:0] retired;
    logic [2:0]  state;

    multicycle_ctrl u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .word_en(word_en), .ld_en(ld_en),
        .ir_write(ir_write), .pc_inc(pc_inc), .pc_write(pc_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .memtoreg(memtoreg),
        .alusrc_a(alusrc_a), .branch(branch), .jump(jump),
        .alusrc_b(alusrc_b), .aluop(aluop), .halted(halted),
        .illegal(illegal), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    logic [17:0] w_ctrl;
    assign w_ctrl = {mem_req, mem_we, word_en, ld_en, ir_write, pc_inc, pc_write,
                     reg_write, reg_dst, memtoreg, alusrc_a, branch, jump,
                     alusrc_b, aluop};

    typedef struct {
        logic [2:0]  st;
        logic [17:0] ctrl;
        logic        rdy;
        logic [15:0] ret;
        logic        ill;
        logic        hlt;
    } rec_t;

    rec_t        r_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cycle = 0;
    logic [15:0] m_ret   = '0;
    logic        m_ill   = 1'b0;
    logic        m_hlt   = 1'b0;

    function automatic logic [17:0] cv(
        input logic mreq, mwe, wen, len, irw, pci, pcw, rw, rd, m2r, asa, br, jp,
        input logic [1:0] asb, input logic [2:0] aop);
        return {mreq, mwe, wen, len, irw, pci, pcw, rw, rd, m2r, asa, br, jp, asb, aop};
    endfunction

    function automatic logic [17:0] c_def();
        return cv(0,0,1,1,0,0,0,0,0,0,0,0,0,2'b00,3'b000);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n_cycle, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [17:0] ctrl, input logic rdy);
        r_q.push_back('{st, ctrl, rdy, m_ret, m_ill, m_hlt});
    endtask

    // Expected per-cycle trace of one instruction, derived from the opcode map
    task automatic gen(input logic [3:0] op, input int nfw, input int nmw, input bit abort);
        logic        is_ill;
        logic [17:0] mc;
        is_ill = (op > 4'h9) || (!c_BYTE_EN && (op == 4'h3 || op == 4'h4));
        for (int i = 0; i < nfw; i++) push(3'd0, cv(1,0,1,1,0,0,0,0,0,0,0,0,0,2'b00,3'b000), 1'b0);
        push(3'd0, cv(1,0,1,1,1,1,0,0,0,0,0,0,0,2'b00,3'b000), 1'b1);
        push(3'd1, c_def(), 1'b1);
        if (is_ill) begin
            m_ill = 1'b1;
        end else if (op == 4'h9) begin
            m_ret++;
            m_hlt = 1'b1;
        end else if (op <= 4'h1) begin
            push(3'd2, cv(0,0,1,1,0,0,0,0,0,0,0,0,0,2'b00,(op == 4'h0) ? 3'b010 : 3'b011), 1'b1);
            push(3'd4, cv(0,0,1,1,0,0,0,1,1,0,0,0,0,2'b00,3'b000), 1'b1);
            m_ret++;
        end else if (op <= 4'h5) begin
            push(3'd2, cv(0,0,1,1,0,0,0,0,0,0,0,0,0,2'b11,3'b000), 1'b1);
            mc = cv(1, (op == 4'h4 || op == 4'h5), (op != 4'h4), (op != 4'h3),
                    0,0,0,0,0,0,0,0,0,2'b00,3'b000);
            for (int i = 0; i < nmw; i++) push(3'd3, mc, 1'b0);
            if (!abort) begin
                push(3'd3, mc, 1'b1);
                if (op == 4'h4 || op == 4'h5) begin
                    m_ret++;
                end else begin
                    push(3'd4, cv(0,0,1,(op != 4'h3),0,0,0,1,0,1,0,0,0,2'b00,3'b000), 1'b1);
                    m_ret++;
                end
            end
        end else if (op <= 4'h7) begin
            push(3'd2, cv(0,0,1,1,0,0,0,0,0,0,0,1,0,2'b00,(op == 4'h6) ? 3'b110 : 3'b111), 1'b1);
            m_ret++;
        end else begin
            push(3'd2, cv(0,0,1,1,0,0,1,0,0,0,1,0,1,2'b01,3'b100), 1'b1);
            m_ret++;
        end
    endtask

    task automatic drain();
        rec_t r;
        while (r_q.size() > 0) begin
            r = r_q.pop_front();
            mem_ready = r.rdy;
            @(negedge clk);
            check("state",   32'(state),   32'(r.st));
            check("ctrl",    32'(w_ctrl),  32'(r.ctrl));
            check("retired", 32'(retired), 32'(r.ret));
            check("illegal", 32'(illegal), 32'(r.ill));
            check("halted",  32'(halted),  32'(r.hlt));
            @(posedge clk);
            #1;
            n_cycle++;
            // Scramble the opcode once latched; outputs must follow op_q only
            if (r.st == 3'd1) opcode = 4'hF;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input int nfw, input int nmw);
        opcode = op;
        gen(op, nfw, nmw, 1'b0);
        drain();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        m_ret = '0;
        m_ill = 1'b0;
        m_hlt = 1'b0;
        for (int i = 0; i < n; i++) push(3'd0, c_def(), 1'b0);
        drain();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", n_cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        opcode    = 4'h0;
        mem_ready = 1'b0;
        do_reset(2);

        run_instr(4'h0, 0, 0);   // ADD
        run_instr(4'h2, 0, 3);   // LW, three MEM waits
        run_instr(4'h4, 0, 0);   // SB
        run_instr(4'h6, 0, 0);   // BEQ
        run_instr(4'h8, 0, 0);   // J
        run_instr(4'h1, 2, 0);   // SUB, two FETCH waits
        run_instr(4'h3, 0, 1);   // LB
        run_instr(4'h5, 0, 2);   // SW
        run_instr(4'h7, 1, 0);   // BNE
        run_instr(4'hC, 0, 0);   // illegal

        // Abort a load mid-MEM wait with reset
        opcode = 4'h2;
        gen(4'h2, 0, 2, 1'b1);
        drain();
        do_reset(2);

        run_instr(4'hC, 0, 0);
        opcode = 4'h9;
        gen(4'h9, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++) push(3'd5, c_def(), 1'b1);
        drain();
        check("final_retired", 32'(retired), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
